// File: rtl/vending_pkg.sv
// Shared types and constants for the vending controller: FSM states,
// credit width and the fixed per-product price table.
package vending_pkg;

    localparam int CREDIT_W = 4;

    typedef logic [CREDIT_W-1:0] credit_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DISPENSE,
        REFUND,
        CLEAR
    } state_t;

    // Indexed directly by the 2-bit product select.
    localparam credit_t PRICE [4] = '{4'd3, 4'd5, 4'd8, 4'd12};

    // Saturating subtract: a wrapped coin counter must never yield huge change.
    function automatic credit_t sat_sub(input credit_t a, input credit_t b);
        return (a >= b) ? credit_t'(a - b) : '0;
    endfunction

endpackage

// File: rtl/credit_sync.sv
// Brings the asynchronous coin-counter total into the clk domain and only
// publishes a new value once two consecutive synchronized samples agree.
module credit_sync
    import vending_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] sync_credit
);

    logic [CREDIT_W-1:0] meta_q;
    logic [CREDIT_W-1:0] sync_q;
    logic [CREDIT_W-1:0] prev_q;

    // NOTE: non-blocking assignments make every flop sample the pre-edge value
    // of its neighbour, which is what turns these lines into a shift chain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q      <= '0;
            sync_q      <= '0;
            prev_q      <= '0;
            sync_credit <= '0;
        end else begin
            meta_q <= credit;
            sync_q <= meta_q;
            prev_q <= sync_q;
            // A multi-bit count can be caught mid-transition; wait for it to settle.
            if (sync_q == prev_q) begin
                sync_credit <= sync_q;
            end
        end
    end

endmodule

// File: rtl/vending_controller.sv
// Vending machine controller: price check, timed dispense strobe, change
// return and a held coin-counter clear, all with registered outputs.
module vending_controller
    import vending_pkg::*;
#(
    parameter int DISP_CYCLES  = 4,
    parameter int CLEAR_CYCLES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CREDIT_W-1:0] credit,
    input  logic [1:0]          sel,
    input  logic                buy,
    input  logic                cancel,
    output logic                credit_clear_n,
    output logic                dispense,
    output logic [1:0]          product,
    output logic [CREDIT_W-1:0] change,
    output logic                change_valid,
    output logic                insufficient,
    output logic                busy
);

    localparam logic [3:0] DISP_LAST  = 4'(DISP_CYCLES - 1);
    localparam logic [3:0] CLEAR_LAST = 4'(CLEAR_CYCLES - 1);

    state_t              state;
    logic [3:0]          cnt;
    logic [CREDIT_W-1:0] sync_credit;

    credit_sync u_credit_sync (
        .clk         (clk),
        .reset       (reset),
        .credit      (credit),
        .sync_credit (sync_credit)
    );

    // Outputs are assigned alongside the state transition, so each output
    // is a flop that changes on the same edge as the state it belongs to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            credit_clear_n <= 1'b1;
            dispense       <= 1'b0;
            product        <= '0;
            change         <= '0;
            change_valid   <= 1'b0;
            insufficient   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            change_valid <= 1'b0;
            change       <= '0;
            insufficient <= 1'b0;

            case (state)
                IDLE: begin
                    if (cancel) begin
                        if (sync_credit != '0) begin
                            state        <= REFUND;
                            busy         <= 1'b1;
                            change_valid <= 1'b1;
                            change       <= sync_credit;
                        end
                    end else if (buy) begin
                        state   <= CHECK;
                        busy    <= 1'b1;
                        product <= sel;
                    end
                end

                CHECK: begin
                    if (sync_credit >= PRICE[product]) begin
                        state    <= DISPENSE;
                        dispense <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        insufficient <= 1'b1;
                    end
                end

                DISPENSE: begin
                    if (cnt == DISP_LAST) begin
                        // Credit is re-read here so coins added while dispensing come back.
                        state        <= REFUND;
                        dispense     <= 1'b0;
                        change_valid <= 1'b1;
                        change       <= sat_sub(sync_credit, PRICE[product]);
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                REFUND: begin
                    state          <= CLEAR;
                    credit_clear_n <= 1'b0;
                    cnt            <= '0;
                end

                CLEAR: begin
                    if (cnt >= CLEAR_LAST && sync_credit == '0) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        credit_clear_n <= 1'b1;
                        cnt            <= '0;
                    end else if (cnt < CLEAR_LAST) begin
                        cnt <= cnt + 4'd1;
                    end
                end

                default: begin
                    state          <= IDLE;
                    busy           <= 1'b0;
                    dispense       <= 1'b0;
                    credit_clear_n <= 1'b1;
                    cnt            <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller: a table of purchase/refund vectors
// plus hand-written sequences for reset mid-dispense and a stuck coin counter.
module tb_vending_controller;

    localparam int DISP_CYCLES  = 4;
    localparam int CLEAR_CYCLES = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] credit;
    logic [1:0] sel;
    logic       buy;
    logic       cancel;
    logic       credit_clear_n;
    logic       dispense;
    logic [1:0] product;
    logic [3:0] change;
    logic       change_valid;
    logic       insufficient;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;
    bit auto_clear = 1'b1;

    always #5 clk = ~clk;

    vending_controller #(
        .DISP_CYCLES  (DISP_CYCLES),
        .CLEAR_CYCLES (CLEAR_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .credit         (credit),
        .sel            (sel),
        .buy            (buy),
        .cancel         (cancel),
        .credit_clear_n (credit_clear_n),
        .dispense       (dispense),
        .product        (product),
        .change         (change),
        .change_valid   (change_valid),
        .insufficient   (insufficient),
        .busy           (busy)
    );

    typedef struct {
        logic [3:0] credit;
        logic [3:0] late;
        logic [1:0] sel;
        bit         buy;
        bit         cancel;
        bit         noise;
        int         exp_disp;
        int         exp_prod;
        int         exp_cv;
        int         exp_change;
        int         exp_ins;
        bit         exp_clear;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input int c, input int l, input int s, input bit b,
                                input bit x, input bit n, input int d, input int p,
                                input int cv, input int ch, input int ins, input bit clr);
        vec_t v;
        v.credit = 4'(c);   v.late = 4'(l);     v.sel = 2'(s);
        v.buy = b;          v.cancel = x;       v.noise = n;
        v.exp_disp = d;     v.exp_prod = p;     v.exp_cv = cv;
        v.exp_change = ch;  v.exp_ins = ins;    v.exp_clear = clr;
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Outputs are sampled on the falling edge; the coin counter model then
    // honours credit_clear_n just as the real counter would.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (auto_clear && credit_clear_n === 1'b0) credit = '0;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int  disp_n, disp_start, prod_bad, cv_n, cv_at, ch, ins_n, ins_at;
        int  clr_n, nz_change, busy1;
        bit  done;
        string t;
        disp_n = 0; disp_start = -1; prod_bad = 0; cv_n = 0; cv_at = -1; ch = -1;
        ins_n = 0; ins_at = -1; clr_n = 0; nz_change = 0; busy1 = 0; done = 1'b0;
        t = $sformatf("v%0d", k);

        credit = v.credit;
        sel    = v.sel;
        repeat (6) tick();
        buy    = v.buy;
        cancel = v.cancel;

        for (int idx = 1; idx <= 40; idx++) begin
            tick();
            if (idx == 1) begin
                buy    = 1'b0;
                cancel = 1'b0;
                credit = v.late;
                busy1  = int'(busy);
            end
            if (v.noise && idx == 3) begin buy = 1'b1; cancel = 1'b1; end
            if (v.noise && idx == 4) begin buy = 1'b0; cancel = 1'b0; end
            if (dispense) begin
                disp_n++;
                if (disp_start < 0) disp_start = idx;
                if (int'(product) != v.exp_prod) prod_bad++;
            end
            if (change_valid) begin
                cv_n++;
                cv_at = idx;
                ch    = int'(change);
            end else if (change != '0) begin
                nz_change++;
            end
            if (insufficient) begin ins_n++; ins_at = idx; end
            if (!credit_clear_n) clr_n++;
            if (idx >= 2 && !busy) begin done = 1'b1; break; end
        end

        check({t, " back_to_idle"}, int'(done), 1);
        check({t, " busy_after_request"}, busy1,
              int'(v.exp_disp > 0 || v.exp_ins > 0 || v.exp_cv > 0));
        check({t, " dispense_cycles"}, disp_n, v.exp_disp);
        if (v.exp_disp > 0) begin
            check({t, " dispense_start"}, disp_start, 2);
            check({t, " product_bad_cycles"}, prod_bad, 0);
        end
        check({t, " change_valid_count"}, cv_n, v.exp_cv);
        if (v.exp_cv > 0) begin
            check({t, " change"}, ch, v.exp_change);
            check({t, " change_valid_cycle"}, cv_at, (v.exp_disp > 0) ? 2 + DISP_CYCLES : 1);
        end
        check({t, " insufficient_count"}, ins_n, v.exp_ins);
        if (v.exp_ins > 0) check({t, " insufficient_cycle"}, ins_at, 2);
        check({t, " clear_seen"}, int'(clr_n > 0), int'(v.exp_clear));
        if (v.exp_clear) check({t, " clear_min_len"}, int'(clr_n >= CLEAR_CYCLES), 1);
        check({t, " change_nonzero_outside_refund"}, nz_change, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int disp_seen, cv_seen, low_n, ok;

        //        credit late sel buy can noise disp prod cv chg ins clr
        vecs[0]  = mk( 7,  7,  1, 1, 0, 0, 4, 1, 1, 2, 0, 1);
        vecs[1]  = mk( 5,  5,  2, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[2]  = mk( 6,  6,  0, 1, 1, 0, 0, 0, 1, 6, 0, 1);
        vecs[3]  = mk( 3,  3,  0, 1, 0, 0, 4, 0, 1, 0, 0, 1);
        vecs[4]  = mk(11, 11,  3, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[5]  = mk(15, 15,  3, 1, 0, 0, 4, 3, 1, 3, 0, 1);
        vecs[6]  = mk( 0,  0,  0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[7]  = mk( 9,  9,  2, 0, 1, 0, 0, 0, 1, 9, 0, 1);
        vecs[8]  = mk( 0,  0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Coins land while dispensing (13) and a wrapped counter (2): re-read at refund.
        vecs[9]  = mk( 8, 13,  2, 1, 0, 0, 4, 2, 1, 5, 0, 1);
        vecs[10] = mk( 8,  2,  2, 1, 0, 0, 4, 2, 1, 0, 0, 1);
        vecs[11] = mk( 5,  5,  1, 1, 0, 1, 4, 1, 1, 0, 0, 1);
        vecs[12] = mk(14, 14,  3, 1, 0, 0, 4, 3, 1, 2, 0, 1);

        reset = 1'b0; credit = '0; sel = '0; buy = 1'b0; cancel = 1'b0;
        repeat (3) tick();
        check("rst dispense",       int'(dispense),       0);
        check("rst change_valid",   int'(change_valid),   0);
        check("rst insufficient",   int'(insufficient),   0);
        check("rst busy",           int'(busy),           0);
        check("rst change",         int'(change),         0);
        check("rst product",        int'(product),        0);
        check("rst credit_clear_n", int'(credit_clear_n), 1);
        reset = 1'b1;
        repeat (2) tick();

        for (int k = 0; k < 13; k++) run_vec(vecs[k], k);

        // Reset on the second dispense cycle.
        credit = 4'd12; sel = 2'd3;
        repeat (6) tick();
        buy = 1'b1;
        tick();
        buy = 1'b0;
        tick();
        tick();
        check("rstdisp dispense_before", int'(dispense), 1);
        reset = 1'b0;
        tick();
        check("rstdisp dispense",       int'(dispense),       0);
        check("rstdisp busy",           int'(busy),           0);
        check("rstdisp change_valid",   int'(change_valid),   0);
        check("rstdisp credit_clear_n", int'(credit_clear_n), 1);
        check("rstdisp product",        int'(product),        0);
        reset = 1'b1;
        disp_seen = 0; cv_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dispense) disp_seen++;
            if (change_valid) cv_seen++;
        end
        check("rstdisp later_dispense",     disp_seen, 0);
        check("rstdisp later_change_valid", cv_seen,   0);

        // Coin counter ignores the clear: CLEAR must hold until credit reads zero.
        auto_clear = 1'b0;
        credit = 4'd4; sel = 2'd0;
        repeat (6) tick();
        buy = 1'b1;
        tick();
        buy = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!credit_clear_n) begin ok = 1; break; end
        end
        check("stuck clear_asserted", ok, 1);
        low_n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!credit_clear_n && busy) low_n++;
        end
        check("stuck clear_held", low_n, 12);
        credit = '0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!busy) begin ok = 1; break; end
        end
        check("stuck returns_idle", ok, 1);
        check("stuck credit_clear_n", int'(credit_clear_n), 1);
        auto_clear = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/vending_controller.md
VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 Parameter DISP_CYCLES, default 4: cycles dispense is held high, legal 1..15.
REQ-002 Parameter CLEAR_CYCLES, default 3: minimum cycles credit_clear_n is held low, legal 3..15.
REQ-003 Port clk  in  1  single system clock, all logic on rising edge.
REQ-004 Port reset  in  1  synchronous, active-low reset.
REQ-005 Port credit  in  4  coin counter total in units of 100, not synchronous to clk.
REQ-006 Port sel  in  2  product select, 0..3.
REQ-007 Port buy  in  1  single-cycle purchase request, synchronous to clk.
REQ-008 Port cancel  in  1  single-cycle refund request, synchronous to clk.
REQ-009 Port credit_clear_n  out  1  active-low clear, drives the coin counter reset.
REQ-010 Port dispense  out  1  product release strobe.
REQ-011 Port product  out  2  product being dispensed, valid while dispense=1.
REQ-012 Port change  out  4  change in units of 100, valid while change_valid=1.
REQ-013 Port change_valid  out  1  single-cycle change strobe.
REQ-014 Port insufficient  out  1  single-cycle rejected-purchase strobe.
REQ-015 Port busy  out  1  high in every state except IDLE.

Function
REQ-016 credit SHALL pass through a 2-flop synchronizer; the value used (sync_credit) SHALL update only when two consecutive synchronized samples match.
REQ-017 The price table SHALL be fixed: sel 0=3, 1=5, 2=8, 3=12 units.
REQ-018 The FSM SHALL have the states IDLE, CHECK, DISPENSE, REFUND and CLEAR.
REQ-019 IDLE: cancel=1 with sync_credit>0 SHALL go to REFUND with refund-all mode; cancel=1 with sync_credit=0 SHALL be ignored.
REQ-020 IDLE: buy=1 with cancel=0 SHALL latch sel into product and go to CHECK.
REQ-021 IDLE: if buy and cancel are both 1, cancel SHALL take priority.
REQ-022 CHECK SHALL last one cycle. If sync_credit>=price, go to DISPENSE. Otherwise pulse insufficient for one cycle and return to IDLE, with credit kept.
REQ-023 DISPENSE SHALL hold dispense=1 for exactly DISP_CYCLES cycles, then go to REFUND.
REQ-024 REFUND SHALL last one cycle with change_valid=1. change SHALL equal sync_credit−price in the purchase path and sync_credit in refund-all mode.
REQ-025 The REFUND subtraction SHALL be computed at that cycle, so coins inserted during DISPENSE are returned.
REQ-026 If sync_credit<price in REFUND (counter wrap), change SHALL be 0; the subtraction SHALL saturate and never wrap.
REQ-027 CLEAR SHALL drive credit_clear_n=0. It SHALL stay in CLEAR for at least CLEAR_CYCLES cycles and until sync_credit=0, then return to IDLE.
REQ-028 buy and cancel SHALL be ignored in every state except IDLE; they SHALL not be queued.
REQ-029 Outside REFUND, change SHALL be 0. Outside DISPENSE, product SHALL hold its last value and dispense SHALL be 0.
REQ-030 All outputs SHALL be registered: one cycle of latency from a state entry to the corresponding output.

Reset
REQ-031 reset=0 at a clock edge SHALL force the state to IDLE, from any state and mid-operation.
REQ-032 Reset SHALL set dispense=0, change_valid=0, insufficient=0, busy=0, change=0, product=0, credit_clear_n=1, the synchronizer flops to 0 and all cycle counters to 0.
REQ-033 A reset during DISPENSE SHALL end dispense on the next cycle and SHALL produce no change_valid.

Structure
REQ-034 Package vending_pkg SHALL hold the state enum, CREDIT_W=4, and the price table constant indexed by sel.
REQ-035 Sub-module credit_sync SHALL implement the REQ-016 synchronizer and stability filter (clk, reset, credit in, sync_credit out).
REQ-036 vending_controller SHALL contain the FSM, the shared dispense/clear cycle counter and the output registers.

Verification
REQ-037 credit=7, sel=1, buy pulse -> CHECK passes; dispense high 4 cycles with product=1; change_valid one cycle with change=2; credit_clear_n low until credit=0; back to IDLE.
REQ-038 credit=5, sel=2, buy pulse -> insufficient pulses once; no dispense; no credit_clear_n assertion; FSM stays in IDLE.
REQ-039 credit=6, buy and cancel in the same cycle -> refund-all path; change=6; dispense never asserted.
REQ-040 credit=8, sel=2, buy, then credit steps to 13 during DISPENSE -> change=5.
REQ-041 credit=12, sel=3, buy; reset=0 on the 2nd DISPENSE cycle -> next cycle dispense=0, busy=0; no change_valid; credit_clear_n=1.
REQ-042 cancel with credit=0 -> no response; extra buy pulses during DISPENSE -> ignored, exactly one dispense sequence.
